// File: rtl/power_button_ctrl.sv
// Power button front-end: synchronises and debounces the raw button, then sequences
// power_on / power_off requests to the engine power block based on its power status.
module power_button_ctrl #(
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned IDLE_MS     = 10000
) (
   input  logic       clk_ms,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic       activity,
   input  logic       power,
   output logic       power_on,
   output logic       power_off,
   output logic       btn_db,
   output logic [2:0] state
);

   localparam int unsigned DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
   localparam int unsigned IW = (IDLE_MS > 1) ? $clog2(IDLE_MS) : 1;
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_MS - 1);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_HOLD    = 3'd1,
      S_ON_REL  = 3'd2,
      S_RUN     = 3'd3,
      S_OFF_REQ = 3'd4,
      S_OFF_REL = 3'd5
   } state_t;

   state_t          cur;
   state_t          nxt;
   logic            sync_q;
   logic            btn_s;
   logic [DW-1:0]   db_cnt;
   logic            btn_db_q;
   logic [IW-1:0]   idle_cnt;
   logic            db_rise;
   logic            idle_timeout;

   assign state = cur;

   // Two-flop synchroniser for the asynchronous button pin
   always_ff @(posedge clk_ms or negedge rst) begin
      if (!rst) begin
         sync_q <= 1'b0;
         btn_s  <= 1'b0;
      end else begin
         sync_q <= btn_raw;
         btn_s  <= sync_q;
      end
   end

   // Debouncer: level only follows btn_s after DEBOUNCE_MS consecutive differing samples
   always_ff @(posedge clk_ms or negedge rst) begin
      if (!rst) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
      end else begin
         btn_db_q <= btn_db;
         if (btn_s == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

   assign db_rise      = btn_db & ~btn_db_q;
   assign idle_timeout = (cur == S_RUN) && (idle_cnt == IDLE_LAST) && !activity;

   // Next-state logic; the release states force a button release before re-arming
   always_comb begin
      nxt = cur;
      case (cur)
         S_OFF: begin
            if (power)       nxt = S_ON_REL;
            else if (btn_db) nxt = S_HOLD;
         end
         S_HOLD: begin
            if (power)        nxt = S_ON_REL;
            else if (!btn_db) nxt = S_OFF;
         end
         S_ON_REL: begin
            if (!btn_db) nxt = S_RUN;
         end
         S_RUN: begin
            if (!power)                       nxt = S_OFF;
            else if (db_rise || idle_timeout) nxt = S_OFF_REQ;
         end
         S_OFF_REQ: begin
            if (!power) nxt = S_OFF_REL;
         end
         S_OFF_REL: begin
            if (!btn_db) nxt = S_OFF;
         end
         default: nxt = S_OFF;
      endcase
   end

   // State register with request outputs registered from the next state
   always_ff @(posedge clk_ms or negedge rst) begin
      if (!rst) begin
         cur       <= S_OFF;
         power_on  <= 1'b0;
         power_off <= 1'b0;
      end else begin
         cur       <= nxt;
         power_on  <= (nxt == S_HOLD);
         power_off <= (nxt == S_OFF_REQ);
      end
   end

   // Inactivity counter, only counts while staying in RUN
   always_ff @(posedge clk_ms or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if ((cur == S_RUN) && (nxt == S_RUN) && !activity) begin
         idle_cnt <= idle_cnt + IW'(1);
      end else begin
         idle_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_power_button_ctrl.sv
// Scoreboard bench for power_button_ctrl with a simple engine power block model.
module tb_power_button_ctrl;

   localparam int unsigned DEBOUNCE_MS    = 20;
   localparam int unsigned IDLE_MS        = 100;
   localparam int          ENGINE_HOLD_MS = 1001;

   logic       clk_ms   = 1'b0;
   logic       rst      = 1'b0;
   logic       btn_raw  = 1'b0;
   logic       activity = 1'b0;
   logic       power    = 1'b0;
   logic       power_on;
   logic       power_off;
   logic       btn_db;
   logic [2:0] state;

   logic eng_loss  = 1'b0;
   int   on_cnt    = 0;
   int   checks    = 0;
   int   errors    = 0;
   logic pon_seen  = 1'b0;
   logic poff_seen = 1'b0;
   logic db_seen   = 1'b0;

   typedef struct {
      string      name;
      logic [5:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   power_button_ctrl #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .IDLE_MS    (IDLE_MS)
   ) dut (
      .clk_ms   (clk_ms),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .activity (activity),
      .power    (power),
      .power_on (power_on),
      .power_off(power_off),
      .btn_db   (btn_db),
      .state    (state)
   );

   always #5 clk_ms = ~clk_ms;

   // Engine model: powers up after a continuous power_on hold, drops on power_off or forced loss
   always @(posedge clk_ms) begin
      #2;
      if (power_on) on_cnt = on_cnt + 1;
      else          on_cnt = 0;
      if (on_cnt >= ENGINE_HOLD_MS) power = 1'b1;
      if (power_off || eng_loss)    power = 1'b0;
   end

   function automatic exp_t mk(input string n, input logic db, input logic pon,
                               input logic poff, input logic [2:0] st);
      exp_t r;
      r.name = n;
      r.val  = {db, pon, poff, st};
      return r;
   endfunction

   function automatic logic [5:0] snap();
      return {btn_db, power_on, power_off, state};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_ms);
         pon_seen  = pon_seen | power_on;
         poff_seen = poff_seen | power_off;
         db_seen   = db_seen | btn_db;
      end
   endtask

   task automatic test_reset();
      exp_q.push_back(mk("reset_state", 1'b0, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("db_latency", 1'b1, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("hold_entry", 1'b1, 1'b1, 1'b0, 3'd1));
      exp_q.push_back(mk("rst_async_hold", 1'b0, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("rst_held", 1'b0, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("rst_release", 1'b0, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("rst_settle", 1'b0, 1'b0, 1'b0, 3'd0));
      rst = 1'b0;
      btn_raw = 1'b0;
      tick(3);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      rst = 1'b1;
      btn_raw = 1'b1;
      tick(DEBOUNCE_MS + 2);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      #1 rst = 1'b0;
      #1;
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(3);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      rst = 1'b1;
      btn_raw = 1'b0;
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(30);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
   endtask

   task automatic test_bounce();
      exp_q.push_back(mk("bounce_final", 1'b0, 1'b0, 1'b0, 3'd0));
      db_seen  = 1'b0;
      pon_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         btn_raw = (((i / 5) % 2) == 0);
         tick(1);
      end
      btn_raw = 1'b0;
      tick(25);
      checks++;
      if ({db_seen, pon_seen} !== 2'b00) begin
         errors++;
         $display("FAIL bounce_seen: got db=%b pon=%b want db=0 pon=0", db_seen, pon_seen);
      end
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
   endtask

   task automatic test_short_press();
      exp_q.push_back(mk("short_db_rise", 1'b1, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("short_pon_rise", 1'b1, 1'b1, 1'b0, 3'd1));
      exp_q.push_back(mk("short_holding", 1'b1, 1'b1, 1'b0, 3'd1));
      exp_q.push_back(mk("short_db_fall", 1'b0, 1'b1, 1'b0, 3'd1));
      exp_q.push_back(mk("short_back_off", 1'b0, 1'b0, 1'b0, 3'd0));
      btn_raw = 1'b1;
      tick(22);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(477);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      btn_raw = 1'b0;
      tick(22);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      checks++;
      if (power !== 1'b0) begin
         errors++;
         $display("FAIL short_no_power: got power=%b want 0", power);
      end
   endtask

   // Long press from OFF to RUN; leaves the DUT in RUN with the button released
   task automatic test_power_on();
      int n;
      exp_q.push_back(mk("on_db_rise", 1'b1, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("on_pon_rise", 1'b1, 1'b1, 1'b0, 3'd1));
      exp_q.push_back(mk("on_pon_drop", 1'b1, 1'b0, 1'b0, 3'd2));
      exp_q.push_back(mk("on_db_fall", 1'b0, 1'b0, 1'b0, 3'd2));
      exp_q.push_back(mk("on_run", 1'b0, 1'b0, 1'b0, 3'd3));
      activity = 1'b1;
      btn_raw = 1'b1;
      tick(22);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      n = 0;
      while (power !== 1'b1 && n < 1100) begin
         tick(1);
         n++;
      end
      checks++;
      if (n != ENGINE_HOLD_MS - 1) begin
         errors++;
         $display("FAIL on_power_wait: got %0d ms want %0d ms", n, ENGINE_HOLD_MS - 1);
      end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1200 - 24 - n);
      btn_raw = 1'b0;
      tick(22);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
   endtask

   task automatic test_manual_off();
      exp_q.push_back(mk("off_db_rise", 1'b1, 1'b0, 1'b0, 3'd3));
      exp_q.push_back(mk("off_req", 1'b1, 1'b0, 1'b1, 3'd4));
      exp_q.push_back(mk("off_rel", 1'b1, 1'b0, 1'b0, 3'd5));
      exp_q.push_back(mk("off_rel_held", 1'b1, 1'b0, 1'b0, 3'd5));
      exp_q.push_back(mk("off_db_fall", 1'b0, 1'b0, 1'b0, 3'd5));
      exp_q.push_back(mk("off_done", 1'b0, 1'b0, 1'b0, 3'd0));
      pon_seen = 1'b0;
      btn_raw = 1'b1;
      tick(22);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(26);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      btn_raw = 1'b0;
      tick(22);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      checks++;
      if (pon_seen !== 1'b0) begin
         errors++;
         $display("FAIL off_no_pon: got power_on seen=%b want 0", pon_seen);
      end
   endtask

   task automatic test_idle_timeout();
      exp_q.push_back(mk("idle_before", 1'b0, 1'b0, 1'b0, 3'd3));
      exp_q.push_back(mk("idle_timeout", 1'b0, 1'b0, 1'b1, 3'd4));
      exp_q.push_back(mk("rst_in_off_req", 1'b0, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("rst_off_req_after", 1'b0, 1'b0, 1'b0, 3'd0));
      activity = 1'b0;
      tick(IDLE_MS - 1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      rst = 1'b0;
      #1;
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(2);
      rst = 1'b1;
      tick(5);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      checks++;
      if (power !== 1'b0) begin
         errors++;
         $display("FAIL idle_power_dropped: got power=%b want 0", power);
      end
      activity = 1'b1;
   endtask

   task automatic test_activity_pulses();
      exp_q.push_back(mk("pulse_still_run", 1'b0, 1'b0, 1'b0, 3'd3));
      poff_seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         activity = ((i % 50) == 49);
         tick(1);
      end
      activity = 1'b1;
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      checks++;
      if (poff_seen !== 1'b0) begin
         errors++;
         $display("FAIL pulse_no_poff: got power_off seen=%b want 0", poff_seen);
      end
   endtask

   task automatic test_power_loss();
      exp_q.push_back(mk("loss_db_rise", 1'b1, 1'b0, 1'b0, 3'd3));
      exp_q.push_back(mk("loss_to_off", 1'b1, 1'b0, 1'b0, 3'd0));
      exp_q.push_back(mk("loss_settle", 1'b0, 1'b0, 1'b0, 3'd0));
      poff_seen = 1'b0;
      btn_raw = 1'b1;
      tick(21);
      eng_loss = 1'b1;
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      tick(1);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
      checks++;
      if (poff_seen !== 1'b0) begin
         errors++;
         $display("FAIL loss_no_poff: got power_off seen=%b want 0", poff_seen);
      end
      btn_raw = 1'b0;
      eng_loss = 1'b0;
      tick(40);
      e = exp_q.pop_front(); checks++; if (snap() !== e.val) begin errors++; $display("FAIL %s: got %b want %b", e.name, snap(), e.val); end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_short_press();
      test_power_on();
      test_manual_off();
      test_power_on();
      test_idle_timeout();
      test_power_on();
      test_activity_pulses();
      test_power_loss();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
